// File: rtl/pfb_polyphase_filter.sv
// rtl/pfb_polyphase_filter.sv - polyphase FIR front end: commutated I/Q branch filters with loadable taps
//
// Purpose: commutates an I/Q sample stream across NUM_CHANNELS branches and runs a
// NUM_COEFS_PER_CHANNEL-tap FIR for each accepted sample, emitting one saturated,
// channel-tagged I/Q result per input.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   input_valid_i           input sample strobe
//   input_data_i            signed I/Q input, [0]=I, [1]=Q
//   input_ready_o           block accepts a sample this cycle
//   coef_wr_valid_i         coefficient write strobe
//   coef_wr_addr_i          prototype coefficient index (tap*NUM_CHANNELS + channel)
//   coef_wr_data_i          signed Q1.(COEF_WIDTH-1) coefficient
//   output_valid_o          one-cycle output strobe
//   output_index_o          channel of the output sample
//   output_data_o           signed saturated I/Q output, [0]=I, [1]=Q
//   error_overflow_o        pulses with output_valid_o when I or Q saturated
//   error_input_drop_o      pulses the cycle after a sample was offered while not ready
module pfb_polyphase_filter #(
    parameter int NUM_CHANNELS          = 32,
    parameter int NUM_COEFS_PER_CHANNEL = 12,
    parameter int INPUT_DATA_WIDTH      = 16,
    parameter int COEF_WIDTH            = 16,
    parameter int OUTPUT_DATA_WIDTH     = INPUT_DATA_WIDTH + $clog2(NUM_COEFS_PER_CHANNEL),
    parameter int CHANNEL_INDEX_WIDTH   = $clog2(NUM_CHANNELS)
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  input_valid_i,
    input  logic [1:0][INPUT_DATA_WIDTH-1:0]                      input_data_i,
    output logic                                                  input_ready_o,
    input  logic                                                  coef_wr_valid_i,
    input  logic [$clog2(NUM_CHANNELS*NUM_COEFS_PER_CHANNEL)-1:0] coef_wr_addr_i,
    input  logic [COEF_WIDTH-1:0]                                 coef_wr_data_i,
    output logic                                                  output_valid_o,
    output logic [CHANNEL_INDEX_WIDTH-1:0]                        output_index_o,
    output logic [1:0][OUTPUT_DATA_WIDTH-1:0]                     output_data_o,
    output logic                                                  error_overflow_o,
    output logic                                                  error_input_drop_o
);

    localparam int N     = NUM_CHANNELS;
    localparam int K     = NUM_COEFS_PER_CHANNEL;
    localparam int IW    = INPUT_DATA_WIDTH;
    localparam int CFW   = COEF_WIDTH;
    localparam int OW    = OUTPUT_DATA_WIDTH;
    localparam int CW    = CHANNEL_INDEX_WIDTH;
    localparam int SW    = $clog2(K);
    localparam int AW    = $clog2(N * K);
    localparam int DEPTH = N * K;
    localparam int ACCW  = IW + CFW + $clog2(K);
    localparam int TW    = $clog2(K + 2);

    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TAP_ISSUE_END = TW'(K);
    localparam logic [TW-1:0] TAP_LAST = TW'(K + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(K - 1);

    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_MAC, ST_OUTPUT} state_t;

    state_t state_q, state_d;

    logic [AW-1:0]         clr_cnt_q;
    logic [TW-1:0]         tap_q;
    logic [CW-1:0]         c_q;
    logic [SW-1:0]         s_q;
    logic                  rd_vld_q;
    logic                  rd_first_q;
    logic signed [ACCW-1:0] acc_re_q, acc_im_q;

    logic                  out_valid_q;
    logic [CW-1:0]         out_index_q;
    logic [OW-1:0]         out_re_q, out_im_q;
    logic                  ovf_q;
    logic                  drop_q;

    logic [2*IW-1:0]       dl_ram [DEPTH];
    logic signed [CFW-1:0] coef_ram [DEPTH];
    logic [2*IW-1:0]       rd_word_q;
    logic signed [CFW-1:0] coef_rd_q;

    logic                  dl_we;
    logic [AW-1:0]         dl_waddr;
    logic [2*IW-1:0]       dl_wdata;
    logic                  accept;
    logic                  mac_done;
    logic [SW-1:0]         tap_k;
    logic [SW-1:0]         rd_slot;

    logic signed [IW-1:0]   rd_re, rd_im;
    logic signed [ACCW-1:0] prod_re, prod_im;
    logic [OW:0]            sat_re, sat_im;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. MAC spans K read-issue cycles, one cycle for the last
    // read to land in the accumulator and one to saturate into the output register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR:  if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
            ST_IDLE:   if (input_valid_i) state_d = ST_MAC;
            ST_MAC:    if (tap_q == TAP_LAST) state_d = ST_OUTPUT;
            ST_OUTPUT: state_d = ST_IDLE;
            default:   state_d = ST_CLEAR;
        endcase
    end

    // FSM outputs: handshake and delay-line write port
    always_comb begin
        input_ready_o = (state_q == ST_IDLE);
        accept        = (state_q == ST_IDLE) && input_valid_i;
        dl_we         = (state_q == ST_CLEAR) || accept;
        dl_waddr      = (state_q == ST_CLEAR) ? clr_cnt_q : {s_q, c_q};
        dl_wdata      = (state_q == ST_CLEAR) ? '0 : input_data_i;
        mac_done      = (state_q == ST_MAC) && (tap_q == TAP_LAST);
    end

    // Tap k reads slot (s-k) mod K; for non-power-of-2 K the wrap adds K back.
    assign tap_k   = tap_q[SW-1:0];
    assign rd_slot = (tap_k <= s_q) ? (s_q - tap_k) : (s_q + SW'(K) - tap_k);

    always_ff @(posedge clk_i) begin
        if (dl_we) begin
            dl_ram[dl_waddr] <= dl_wdata;
        end
        if (coef_wr_valid_i) begin
            coef_ram[coef_wr_addr_i] <= coef_wr_data_i;
        end
    end

    // Delay line and coefficient storage share the {tap-or-slot, channel} address layout.
    always_ff @(posedge clk_i) begin
        rd_word_q <= dl_ram[{rd_slot, c_q}];
        coef_rd_q <= coef_ram[{tap_k, c_q}];
    end

    assign rd_re   = rd_word_q[IW-1:0];
    assign rd_im   = rd_word_q[2*IW-1:IW];
    assign prod_re = ACCW'(rd_re) * ACCW'(coef_rd_q);
    assign prod_im = ACCW'(rd_im) * ACCW'(coef_rd_q);

    // Returns {saturated, value}
    function automatic logic [OW:0] saturate(input logic signed [ACCW-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b1, SAT_MAX[OW-1:0]};
        end else if (v < SAT_MIN) begin
            return {1'b1, SAT_MIN[OW-1:0]};
        end else begin
            return {1'b0, v[OW-1:0]};
        end
    endfunction

    assign sat_re = saturate(acc_re_q >>> (CFW - 1));
    assign sat_im = saturate(acc_im_q >>> (CFW - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_cnt_q   <= '0;
            tap_q       <= '0;
            c_q         <= '0;
            s_q         <= '0;
            rd_vld_q    <= 1'b0;
            rd_first_q  <= 1'b0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            if (state_q == ST_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end

            tap_q <= (state_q == ST_MAC) ? tap_q + 1'b1 : '0;

            // Read results arrive one cycle after issue; tap 0 restarts the sum.
            rd_vld_q   <= (state_q == ST_MAC) && (tap_q < TAP_ISSUE_END);
            rd_first_q <= (state_q == ST_MAC) && (tap_q == '0);
            if (rd_vld_q) begin
                acc_re_q <= (rd_first_q ? '0 : acc_re_q) + prod_re;
                acc_im_q <= (rd_first_q ? '0 : acc_im_q) + prod_im;
            end

            out_valid_q <= mac_done;
            ovf_q       <= mac_done && (sat_re[OW] || sat_im[OW]);
            if (mac_done) begin
                out_index_q <= c_q;
                out_re_q    <= sat_re[OW-1:0];
                out_im_q    <= sat_im[OW-1:0];
            end

            // Advance the commutator once the result has been emitted.
            if (state_q == ST_OUTPUT) begin
                c_q <= c_q + 1'b1;
                if (c_q == '1) begin
                    s_q <= (s_q == SLOT_LAST) ? '0 : s_q + 1'b1;
                end
            end

            drop_q <= input_valid_i && !input_ready_o;
        end
    end

    assign output_valid_o     = out_valid_q;
    assign output_index_o     = out_index_q;
    assign output_data_o      = {out_im_q, out_re_q};
    assign error_overflow_o   = ovf_q;
    assign error_input_drop_o = drop_q;

endmodule
